// File: rtl/artemis_rst_sequencer.sv
// rtl/artemis_rst_sequencer.sv - PLL reset sequencer and lock supervisor (optional force restart: ARTEMIS_RST_SEQ_FORCE_EN)
module artemis_rst_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       locked_i,
`ifdef ARTEMIS_RST_SEQ_FORCE_EN
  input  logic       force_rst_i,
`endif
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] retry_count_o,
  output logic [7:0] lock_loss_count_o
);

  // One shared counter serves all timed states, so it is sized for the longest interval.
  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             force_req;
  logic [3:0]       retry_inc;

  logic pll_rst_q, pll_rst_d;
  logic sys_rst_q, sys_rst_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;

`ifdef ARTEMIS_RST_SEQ_FORCE_EN
  assign force_req = force_rst_i;
`else
  assign force_req = 1'b0;
`endif

  assign locked_s  = sync_q[1];
  assign retry_inc = retry_q + 4'd1;

  // Two-flop synchronizer bringing the PLL lock flag into the board clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked_i};
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_PLL_RESET;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      loss_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // Next state, retry/loss bookkeeping and the shared cycle counter.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock seen on the timeout cycle still wins over the retry.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RESET;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = 4'd0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RESET;
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_PLL_RESET;
      end
    endcase

    // A restart request overrides everything, including a same-cycle lock loss count.
    if (force_req) begin
      state_d = ST_PLL_RESET;
      retry_d = 4'd0;
      loss_d  = loss_q;
    end

    // Counter clears on every state change; RUN and FAULT have no timed exit so it holds there.
    if (force_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q != ST_RUN) && (state_q != ST_FAULT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    pll_rst_d = (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  assign pll_rst_o         = pll_rst_q;
  assign sys_rst_o         = sys_rst_q;
  assign ready_o           = ready_q;
  assign fault_o           = fault_q;
  assign retry_count_o     = retry_q;
  assign lock_loss_count_o = loss_q;

endmodule

// File: tb/tb_artemis_rst_sequencer.sv
// tb/tb_artemis_rst_sequencer.sv - scoreboard bench for artemis_rst_sequencer
module tb_artemis_rst_sequencer;

  localparam int PLL_RST = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int MAXR    = 2;

  localparam int PH_RST   = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_STAB  = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FAULT = 4;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       force_rst;
  logic       pll_rst_o, sys_rst_o, ready_o, fault_o;
  logic [3:0] retry_count_o;
  logic [7:0] lock_loss_count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit pll;
    bit sys;
    bit rdy;
    bit flt;
    int retry;
    int loss;
  } exp_t;

  exp_t exp_q[$];

  // model state
  int ph;
  int t;
  int m_retry;
  int m_loss;
  bit hist[$];

  artemis_rst_sequencer #(
    .PLL_RST_CYCLES(PLL_RST),
    .LOCK_STABLE_CYCLES(STABLE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .locked_i(locked),
`ifdef ARTEMIS_RST_SEQ_FORCE_EN
    .force_rst_i(force_rst),
`endif
    .pll_rst_o(pll_rst_o),
    .sys_rst_o(sys_rst_o),
    .ready_o(ready_o),
    .fault_o(fault_o),
    .retry_count_o(retry_count_o),
    .lock_loss_count_o(lock_loss_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = PH_RST;
    t = 0;
    m_retry = 0;
    m_loss = 0;
    hist = '{1'b0, 1'b0};
  endtask

  // Lock flag seen by the sequencer is the input sampled two edges earlier.
  task automatic model_step();
    bit ls;
    ls = hist[1];
    hist.push_front(locked);
    void'(hist.pop_back());
    if (force_rst) begin
      ph = PH_RST;
      t = 0;
      m_retry = 0;
      return;
    end
    case (ph)
      PH_RST: begin
        t++;
        if (t == PLL_RST) begin ph = PH_WAIT; t = 0; end
      end
      PH_WAIT: begin
        if (ls) begin
          ph = PH_STAB; t = 0;
        end else begin
          t++;
          if (t == TIMEOUT) begin
            m_retry++;
            t = 0;
            ph = (m_retry == MAXR) ? PH_FAULT : PH_RST;
          end
        end
      end
      PH_STAB: begin
        if (!ls) begin
          ph = PH_WAIT; t = 0;
        end else begin
          t++;
          if (t == STABLE) begin ph = PH_RUN; m_retry = 0; end
        end
      end
      PH_RUN: begin
        if (!ls) begin
          ph = PH_RST; t = 0;
          if (m_loss < 255) m_loss++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic push_expected();
    exp_t e;
    e.pll   = (ph == PH_RST) || (ph == PH_FAULT);
    e.sys   = (ph != PH_RUN);
    e.rdy   = (ph == PH_RUN);
    e.flt   = (ph == PH_FAULT);
    e.retry = m_retry;
    e.loss  = m_loss;
    exp_q.push_back(e);
  endtask

  // reference model: one expectation per clock edge or reset assertion
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      push_expected();
    end
  end

  // monitor: compares every pending expectation against the DUT outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pll_rst_o !== e.pll || sys_rst_o !== e.sys || ready_o !== e.rdy ||
            fault_o !== e.flt || int'(retry_count_o) != e.retry ||
            int'(lock_loss_count_o) != e.loss) begin
          errors++;
          $display("FAIL outputs @%0t: got pll=%0b sys=%0b rdy=%0b flt=%0b retry=%0d loss=%0d expected pll=%0b sys=%0b rdy=%0b flt=%0b retry=%0d loss=%0d",
                   $time, pll_rst_o, sys_rst_o, ready_o, fault_o, retry_count_o, lock_loss_count_o,
                   e.pll, e.sys, e.rdy, e.flt, e.retry, e.loss);
        end
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // edges until ready rises (-1 on timeout), and how many of them had pll_rst high
  task automatic wait_ready(output int n, output int hi);
    n = 0;
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (pll_rst_o) hi++;
      if (ready_o) return;
    end
    n = -1;
  endtask

  // edges until pll_rst is low (-1 on timeout)
  task automatic wait_pll_low(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!pll_rst_o) return;
    end
    n = -1;
  endtask

  initial begin
    int n, hi, w, pre;
    rst_n = 1'b0;
    locked = 1'b0;
    force_rst = 1'b0;
    wait_neg(3);
    check("reset_pll_rst", pll_rst_o, 1);
    check("reset_sys_rst", sys_rst_o, 1);
    check("reset_ready", ready_o, 0);
    check("reset_fault", fault_o, 0);
    check("reset_retry", retry_count_o, 0);
    check("reset_loss", lock_loss_count_o, 0);
    rst_n = 1'b1;

    // clean bring-up
    wait_pll_low(n);
    check("first_pll_rst_width", n, PLL_RST);
    wait_neg(10);
    locked = 1'b1;
    wait_ready(n, hi);
    check("bringup_release_latency", n, 11);
    check("bringup_no_pll_rst", hi, 0);
    check("bringup_sys_rst", sys_rst_o, 0);
    check("bringup_retry", retry_count_o, 0);

    // lock loss in RUN
    wait_neg(1);
    locked = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (sys_rst_o) break;
    end
    check("lockloss_sys_rst_latency", n, 3);
    check("lockloss_pll_rst_same_edge", pll_rst_o, 1);
    check("lockloss_ready", ready_o, 0);
    check("lockloss_count", lock_loss_count_o, 1);
    w = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!pll_rst_o) break;
      w++;
    end
    check("lockloss_pll_rst_width", w, PLL_RST);

    // glitch while STABLE
    wait_neg(3);
    locked = 1'b1;
    wait_neg(5);
    locked = 1'b0;
    wait_neg(1);
    locked = 1'b1;
    wait_ready(n, hi);
    check("glitch_release_latency", n, 11);
    check("glitch_no_pll_rst", hi, 0);

    // repeated lock loss to saturate the counter
    for (int k = 0; k < 300; k++) begin
      wait_neg(1);
      locked = 1'b0;
      wait_neg(3);
      locked = 1'b1;
      wait_ready(n, hi);
      if (n != 13) begin
        check("relock_latency", n, 13);
        break;
      end
    end
    check("loss_saturated", lock_loss_count_o, 255);

    // timeout and fault
    wait_neg(1);
    locked = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (fault_o) break;
    end
    check("fault_latency", n, 3 + 2 * (PLL_RST + TIMEOUT));
    wait_neg(100);
    check("fault_held", fault_o, 1);
    check("fault_pll_rst", pll_rst_o, 1);
    check("fault_retry", retry_count_o, MAXR);
    check("fault_ready", ready_o, 0);

    // asynchronous reset in STABLE and in RUN
    wait_neg(1);
    locked = 1'b1;
    #3 rst_n = 1'b0;
    #1 check("async_from_fault", fault_o, 0);
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(8);
    #3 rst_n = 1'b0;
    #1 check("async_stable_pll_rst", pll_rst_o, 1);
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(16);
    check("async_reached_run", ready_o, 1);
    #3 rst_n = 1'b0;
    #1 check("async_run_ready", ready_o, 0);
    check("async_run_sys_rst", sys_rst_o, 1);
    check("async_run_loss", lock_loss_count_o, 0);
    wait_neg(1);
    rst_n = 1'b1;
    wait_pll_low(n);
    check("async_restart_pll_rst_width", n, PLL_RST);

    // randomized lock behaviour with occasional resets
    for (int i = 0; i < 40; i++) begin
      wait_neg(1);
      locked = 1'($urandom_range(0, 1));
      wait_neg($urandom_range(1, 40));
      if ($urandom_range(0, 7) == 0) begin
        #3 rst_n = 1'b0;
        wait_neg(1);
        rst_n = 1'b1;
      end
`ifdef ARTEMIS_RST_SEQ_FORCE_EN
      if ($urandom_range(0, 5) == 0) begin
        force_rst = 1'b1;
        wait_neg(1);
        force_rst = 1'b0;
      end
`endif
    end

`ifdef ARTEMIS_RST_SEQ_FORCE_EN
    // force out of FAULT
    wait_neg(1);
    locked = 1'b0;
    #3 rst_n = 1'b0;
    wait_neg(1);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fault_o) break;
    end
    check("force_fault_reached", fault_o, 1);
    force_rst = 1'b1;
    wait_neg(1);
    force_rst = 1'b0;
    check("force_fault_cleared", fault_o, 0);
    check("force_retry_cleared", retry_count_o, 0);
    check("force_pll_rst", pll_rst_o, 1);
    w = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!pll_rst_o) break;
      w++;
    end
    check("force_pll_rst_width", w, PLL_RST);

    // force together with a RUN lock loss
    wait_neg(1);
    locked = 1'b1;
    wait_ready(n, hi);
    check("force_relock", ready_o, 1);
    pre = m_loss;
    wait_neg(1);
    locked = 1'b0;
    wait_neg(2);
    force_rst = 1'b1;
    wait_neg(1);
    force_rst = 1'b0;
    check("force_loss_unchanged", lock_loss_count_o, pre);
    check("force_run_ready", ready_o, 0);
`endif

    wait_neg(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
